enc_stream: RTL
===============

ENC_STREAM -- requirements
Module: enc_stream

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream presents a word on in_data.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  16  one-hot line vector, bit i = decoder output line i.
REQ-007 out_valid  output  1  out_code/out_err hold a result.
REQ-008 out_ready  input  1  downstream takes the result this cycle.
REQ-009 out_code  output  4  4-bit code that drives line i on the team's 4-to-16 decoder.
REQ-010 out_err  output  1  the accepted word was not a legal one-hot vector.
REQ-011 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-012 err_cnt  output  ERR_CNT_W  count of erroneous words accepted, saturating.

Function
REQ-013 Code mapping SHALL be: line i in 0..7 -> code 15-i; line i in 8..15 -> code i-8 (e.g. bit 0 -> 4'hF, bit 7 -> 4'h8, bit 8 -> 4'h0, bit 15 -> 4'h7).
REQ-014 Output stage SHALL be a two-state machine, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (state==EMPTY) or out_ready, combinationally.
REQ-016 Accept occurs when in_valid and in_ready; the result SHALL appear on out_code/out_err with out_valid=1 on the next cycle (latency 1).
REQ-017 EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept (back-to-back, one word per cycle).
REQ-018 While FULL and out_ready=0, out_code and out_err SHALL hold stable and no word is accepted.
REQ-019 in_data with zero bits set SHALL yield out_err=1, out_code=4'h0.
REQ-020 in_data with more than one bit set SHALL yield out_err=1, out_code=4'h0 (default build; see REQ-026).
REQ-021 err_cnt SHALL increment by 1 on each accept whose out_err result is 1, and SHALL saturate at all-ones.
REQ-022 clr_cnt=1 SHALL set err_cnt to 0 next cycle, with priority over a simultaneous increment.
REQ-023 out_code/out_err SHALL not change while EMPTY.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state EMPTY, out_valid=0, out_code=4'h0, out_err=0, err_cnt=0, regardless of handshake in progress; a result held in FULL is discarded.
REQ-025 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-026 Macro ENC_STREAM_PRIORITY_EN: when defined, multi-hot in_data SHALL encode the lowest-index set bit with out_err=0; when undefined, REQ-020 applies. Zero-hot is an error in both builds.

Structure
REQ-027 Package enc_pkg SHALL hold the state typedef (EMPTY/FULL), the line/code widths (16, 4) and the mapping constants of REQ-013.
REQ-028 One sub-module enc_stream_core SHALL hold the combinational one-hot check and mapping; enc_stream holds handshake, registers and counter.

Verification
REQ-029 in_data=16'h0001, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_code=4'hF, out_err=0; repeat for 16'h0080->4'h8, 16'h0100->4'h0, 16'h8000->4'h7.
REQ-030 Stream all 16 one-hot words back-to-back with out_ready=1 -> 16 consecutive results, in_ready constantly 1, no errors.
REQ-031 out_ready=0 for 3 cycles after a result of 4'h5 -> in_ready=0, out_code stays 4'h5; out_ready=1 -> transfer, new word accepted same cycle.
REQ-032 in_data=16'h0000 then 16'h0101 -> out_err=1 both, err_cnt=2 (default build); with ENC_STREAM_PRIORITY_EN, 16'h0101 -> out_code=4'hF, out_err=0, err_cnt=1.
REQ-033 ERR_CNT_W=2, 5 error words -> err_cnt 1,2,3,3,3; clr_cnt together with an error accept -> err_cnt=0.
REQ-034 rst_n pulled low while FULL and out_ready=0 -> out_valid=0, err_cnt=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the one-hot to 4-bit code stream encoder.
// The line-to-code mapping matches the team's 4-to-16 decoder wiring.
package enc_pkg;

  localparam int LINE_W    = 16;
  localparam int CODE_W    = 4;
  // Lines below LO_LINES map downward from LO_BASE; the rest map upward from zero.
  localparam int LO_LINES  = 8;
  localparam int LO_BASE   = 15;
  localparam int HI_OFFSET = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [CODE_W-1:0] line_to_code(input int idx);
    if (idx < LO_LINES) return CODE_W'(LO_BASE - idx);
    else                return CODE_W'(idx - HI_OFFSET);
  endfunction

endpackage

// File: rtl/enc_stream_core.sv
// Combinational one-hot check and line-to-code mapping.
// Define ENC_STREAM_PRIORITY_EN to encode the lowest set line of a multi-hot word instead of flagging it.
module enc_stream_core
  import enc_pkg::*;
(
  input  logic [LINE_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code,
  output logic              o_err
);

  logic              w_found;
  logic              w_multi;
  logic [CODE_W-1:0] w_code;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_multi = 1'b0;
    w_code  = '0;
    for (int i = 0; i < LINE_W; i++) begin
      if (i_data[i]) begin
        if (!w_found) begin
          w_code  = line_to_code(i);
          w_found = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
    end
  end

`ifdef ENC_STREAM_PRIORITY_EN
  assign o_err = !w_found;
`else
  assign o_err = !w_found || w_multi;
`endif

  assign o_code = o_err ? '0 : w_code;

endmodule

// File: rtl/enc_stream.sv
// One-hot to code encoder with a single-entry valid/ready output stage and saturating error counter.
// Optional build macro: ENC_STREAM_PRIORITY_EN (handled in enc_stream_core).
module enc_stream
  import enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LINE_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    out_code,
  output logic                 out_err,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e                r_state;
  logic [CODE_W-1:0]     r_code;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0]     w_code;
  logic                  w_err;
  logic                  w_accept;

  enc_stream_core u_core (
    .i_data (in_data),
    .o_code (w_code),
    .o_err  (w_err)
  );

  assign in_ready = (r_state == EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_code  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= FULL;
            r_code  <= w_code;
            r_err   <= w_err;
          end
        end
        FULL: begin
          if (w_accept) begin
            r_code <= w_code;
            r_err  <= w_err;
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_accept && w_err && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_code  = r_code;
  assign out_err   = r_err;
  assign err_cnt   = r_cnt;

endmodule
